// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the FSM state type and the enable/flush groups it selects between.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_HALTED
   } pipe_state_t;

   localparam int MEM_TIMEOUT_CYCLES = 255;
   localparam int STALL_CNT_W        = 32;
   localparam int WAIT_CNT_W         = 8;

   typedef struct packed {
      logic pc_en;
      logic en_if_id;
      logic en_id_ex;
      logic en_ex_mem;
      logic en_mem_wb;
      logic flush_if_id;
      logic flush_id_ex;
      logic mem_wb_bubble;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_FREEZE = 8'b0000_0000;
   localparam pipe_ctl_t CTL_NORMAL = 8'b1111_1000;
   localparam pipe_ctl_t CTL_STALL  = 8'b0000_1001;

   // Control group for a cycle that is free to advance (no halt, no RAM wait).
   function automatic pipe_ctl_t run_ctl(input logic branch_taken, input logic load_use);
      pipe_ctl_t c;
      c = CTL_NORMAL;
      if (branch_taken) begin
         c.flush_if_id = 1'b1;
         c.flush_id_ex = 1'b1;
      end else if (load_use) begin
         c.pc_en       = 1'b0;
         c.en_if_id    = 1'b0;
         c.flush_id_ex = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/halt controller: Mealy enables from a RUN/MEM_WAIT/HALTED FSM,
// plus a RAM-wait watchdog and a saturating stalled-cycle counter.
module pipe_ctrl
   import pipe_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   halt_mem_wb,
   input  logic                   mem_req_ex_mem,
   input  logic                   mem_ready,
   input  logic                   branch_taken_ex,
   input  logic                   load_use_hazard,
   output logic                   pc_en,
   output logic                   en_if_id,
   output logic                   en_id_ex,
   output logic                   en_ex_mem,
   output logic                   en_mem_wb,
   output logic                   flush_if_id,
   output logic                   flush_id_ex,
   output logic                   mem_wb_bubble,
   output logic                   halted,
   output logic                   mem_timeout,
   output logic [STALL_CNT_W-1:0] stall_count
);

   pipe_state_t           state_q, state_d;
   pipe_ctl_t             ctl;
   logic                  wait_inc, wait_clr;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  timeout_q, timeout_d;
   logic                  stall_inc;

   always_comb begin
      state_d  = state_q;
      ctl      = CTL_FREEZE;
      wait_inc = 1'b0;
      wait_clr = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (halt_mem_wb) begin
               state_d = ST_HALTED;
            end else if (mem_req_ex_mem && !mem_ready) begin
               ctl      = CTL_STALL;
               state_d  = ST_MEM_WAIT;
               wait_inc = 1'b1;
            end else begin
               ctl      = run_ctl(branch_taken_ex, load_use_hazard);
               wait_clr = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            // Halt is only honoured once the outstanding RAM access completes.
            if (!mem_ready) begin
               ctl      = CTL_STALL;
               wait_inc = 1'b1;
            end else if (halt_mem_wb) begin
               state_d  = ST_HALTED;
               wait_clr = 1'b1;
            end else begin
               ctl      = run_ctl(branch_taken_ex, load_use_hazard);
               state_d  = ST_RUN;
               wait_clr = 1'b1;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (wait_clr),
      .inc_i   (wait_inc),
      .count_o (wait_cnt)
   );

   assign timeout_d = timeout_q ||
                      ((state_q == ST_MEM_WAIT) && (wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT_CYCLES)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timeout_q <= 1'b0;
      else        timeout_q <= timeout_d;
   end

   assign stall_inc = !ctl.pc_en && (state_q != ST_HALTED);

   sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (1'b0),
      .inc_i   (stall_inc),
      .count_o (stall_count)
   );

   // Enables are forced low while reset is held, independent of the clock.
   assign {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
           flush_if_id, flush_id_ex, mem_wb_bubble} = rst_n ? ctl : CTL_FREEZE;

   assign halted      = (state_q == ST_HALTED);
   assign mem_timeout = timeout_q;

endmodule
